// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared state enum, segment patterns and BCD sizing for seg7_num_display
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_FORMAT
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Active-low a..g in bits 0..6, dp (bit 7) off; hex A-F kept for completeness.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Decimal digits needed to show 2^width-1.
  function automatic int bcd_digits(input int width);
    logic [63:0] v;
    int          n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0 || n == 0) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - one BCD digit to active-low seven-segment pattern with blank/minus/dp
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       minus,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    if (minus) begin
      seg = SEG_MINUS;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = SEG_TABLE[digit];
    end
    if (dp) begin
      seg[7] = 1'b0;
    end
  end

endmodule

// File: rtl/seg7_num_display.sv
// rtl/seg7_num_display.sv - binary value to multi-digit seven-segment display via sequential double-dabble
module seg7_num_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int DATA_WIDTH  = 20,
  parameter int SIGNED_MODE = 1,
  parameter int DP_POS      = -1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [DATA_WIDTH-1:0]   value,
  input  logic                    value_valid,
  output logic                    ready,
  output logic                    done,
  output logic                    overflow,
  output logic [NUM_DIGITS*8-1:0] segm_out
);

  localparam int         BCD_DIGITS = bcd_digits(DATA_WIDTH);
  localparam int         BCD_W      = BCD_DIGITS * 4;
  localparam logic [5:0] LAST_STEP  = 6'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
  logic [5:0]              cnt_q, cnt_d;
  logic                    sign_q, sign_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic [NUM_DIGITS*8-1:0] segm_q, segm_d, segm_enc;

  logic                    accept;
  logic                    neg_in;
  logic                    ovf_now;
  logic [NUM_DIGITS-1:0]   dig_blank, dig_minus, dig_dp;
  int                      msd, shown, need;

  assign accept = value_valid && ready_q;
  assign neg_in = (SIGNED_MODE != 0) && value[DATA_WIDTH-1];

  always_comb begin : dabble_adjust
    bcd_adj = bcd_q;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
    end
  end

  // Digits shown = significant digits, widened so everything up to the dp stays visible.
  always_comb begin : layout
    dig_blank = '0;
    dig_minus = '0;
    dig_dp    = '0;
    msd       = 0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] != 4'd0) begin
        msd = d;
      end
    end
    shown   = (msd + 1 > DP_POS + 1) ? msd + 1 : DP_POS + 1;
    need    = shown + (sign_q ? 1 : 0);
    ovf_now = (need > NUM_DIGITS);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_minus[i] = ovf_now || (sign_q && i == shown);
      dig_blank[i] = (i >= shown);
      dig_dp[i]    = !ovf_now && (i == DP_POS);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [3:0] bcd_digit;
    if (g < BCD_DIGITS) begin : g_src
      assign bcd_digit = bcd_q[4*g +: 4];
    end else begin : g_zero
      assign bcd_digit = 4'd0;
    end
    seg7_encode u_enc (
      .digit (bcd_digit),
      .blank (dig_blank[g]),
      .minus (dig_minus[g]),
      .dp    (dig_dp[g]),
      .seg   (segm_enc[8*g +: 8])
    );
  end

  always_comb begin : fsm
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    segm_d  = segm_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CONVERT;
          // Unsigned W-bit negate: the most negative input maps to 2^(W-1) exactly.
          mag_d   = neg_in ? (~value) + DATA_WIDTH'(1) : value;
          bcd_d   = '0;
          cnt_d   = '0;
          sign_d  = neg_in;
        end
      end
      ST_CONVERT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], mag_q[DATA_WIDTH-1]};
        mag_d = mag_q << 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = ST_FORMAT;
        end
      end
      ST_FORMAT: begin
        segm_d  = segm_enc;
        ovf_d   = ovf_now;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      segm_q  <= '1;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      segm_q  <= segm_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign segm_out = segm_q;

endmodule

// File: tb/tb_seg7_num_display.sv
// tb/tb_seg7_num_display.sv - directed self-checking bench for seg7_num_display
module tb_seg7_num_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] value;
  logic        valid_a, valid_b;
  logic        ready_a, done_a, ovf_a;
  logic        ready_b, done_b, ovf_b;
  logic [47:0] segm_a, segm_b;
  int          n_checks = 0;
  int          n_fails  = 0;
  int          lat;
  int          n_done;

  always #5 clk = ~clk;

  seg7_num_display dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .value         (value),
    .value_valid   (valid_a),
    .ready         (ready_a),
    .done          (done_a),
    .overflow      (ovf_a),
    .segm_out      (segm_a)
  );

  seg7_num_display #(.DP_POS(2)) dut_dp (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .value         (value),
    .value_valid   (valid_b),
    .ready         (ready_b),
    .done          (done_b),
    .overflow      (ovf_b),
    .segm_out      (segm_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input bit to_dp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (((to_dp ? ready_b : ready_a) !== 1'b1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", to_dp ? ready_b : ready_a, 1);
  endtask

  task automatic wait_done(input bit to_dp, output int cycles);
    cycles = 0;
    @(negedge clk);
    while (((to_dp ? done_b : done_a) !== 1'b1) && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic send(input logic [19:0] v, input bit to_dp, output int cycles);
    wait_ready(to_dp);
    value = v;
    if (to_dp) valid_b = 1'b1;
    else valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    wait_done(to_dp, cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    value   = '0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_segm", segm_a, 48'hFFFF_FFFF_FFFF);
    check("rst_ready", ready_a, 1);
    check("rst_done", done_a, 0);
    check("rst_ovf", ovf_a, 0);
    rst_n = 1'b1;

    send(20'd1234, 0, lat);
    check("lat_1234", lat, 21);
    check("done_1234", done_a, 1);
    check("ready_at_done", ready_a, 0);
    check("segm_1234", segm_a, 48'hFFFF_F9A4_B099);
    check("ovf_1234", ovf_a, 0);
    @(negedge clk);
    check("done_pulse_1234", done_a, 0);
    check("ready_after_1234", ready_a, 1);

    send(20'hFFFD6, 0, lat);
    check("segm_m42", segm_a, 48'hFFFF_FFBF_99A4);
    check("ovf_m42", ovf_a, 0);

    send(20'd0, 0, lat);
    check("segm_0", segm_a, 48'hFFFF_FFFF_FFC0);

    send(20'd524287, 0, lat);
    check("segm_524287", segm_a, 48'h92A4_99A4_80F8);
    check("ovf_524287", ovf_a, 0);

    send(20'h80000, 0, lat);
    check("lat_m524288", lat, 21);
    check("segm_m524288", segm_a, 48'hBFBF_BFBF_BFBF);
    check("ovf_m524288", ovf_a, 1);

    send(20'd99, 0, lat);
    check("segm_99", segm_a, 48'hFFFF_FFFF_9090);
    check("ovf_99", ovf_a, 0);

    send(20'd5, 1, lat);
    check("lat_dp5", lat, 21);
    check("segm_dp5", segm_b, 48'hFFFF_FF40_C092);
    check("ovf_dp5", ovf_b, 0);

    // value_valid while busy must be dropped
    wait_ready(0);
    value   = 20'd8;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_ready", ready_a, 0);
    value   = 20'd7;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    wait_done(0, lat);
    check("segm_8", segm_a, 48'hFFFF_FFFF_FF80);
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_a === 1'b1) n_done++;
    end
    check("busy_no_extra_done", n_done, 0);
    check("segm_8_held", segm_a, 48'hFFFF_FFFF_FF80);

    // abort mid-conversion while an overflow is being shown
    send(20'h80000, 0, lat);
    check("ovf_before_rst", ovf_a, 1);
    wait_ready(0);
    value   = 20'd3;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_segm", segm_a, 48'hFFFF_FFFF_FFFF);
    check("abort_ready", ready_a, 1);
    check("abort_ovf", ovf_a, 0);
    check("abort_done", done_a, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_ready_after", ready_a, 1);
    check("abort_segm_after", segm_a, 48'hFFFF_FFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seg7_num_display.md
SEG7_NUM_DISPLAY -- requirements
Module: seg7_num_display

Interface
REQ-001 The block SHALL have the parameter NUM_DIGITS, default 6, giving the number of seven-segment digits driven (range 1..8).
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 20, giving the width of the input value (range 4..32).
REQ-003 The block SHALL have the parameter SIGNED_MODE, default 1: 1 means the input is two's complement, 0 means it is unsigned.
REQ-004 The block SHALL have the parameter DP_POS, default -1, giving the digit index whose decimal point is lit; -1 means no decimal point.
REQ-005 The block SHALL have the port clk_clk, input, 1 bit: the single clock, rising-edge.
REQ-006 The block SHALL have the port reset_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have the port value, input, DATA_WIDTH bits: the number to display.
REQ-008 The block SHALL have the port value_valid, input, 1 bit: request to display value.
REQ-009 The block SHALL have the port ready, output, 1 bit: the block can accept a value.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle pulse when the display is updated.
REQ-011 The block SHALL have the port overflow, output, 1 bit: the last accepted value does not fit on the display.
REQ-012 The block SHALL have the port segm_out, output, NUM_DIGITS*8 bits: the segment outputs.
- Digit i occupies bits [8i+7:8i]; digit 0 is the rightmost digit.
- Bit order within a digit: bit0..bit6 = segments a..g, bit7 = dp.
- All segment bits are active-low.

Function
REQ-013 A value SHALL be accepted on a rising edge where value_valid=1 and ready=1; value_valid is ignored while ready=0.
REQ-014 The state machine SHALL have the states IDLE, CONVERT and FORMAT, with the following transitions:
- IDLE -> CONVERT on acceptance.
- CONVERT -> FORMAT after exactly DATA_WIDTH shift cycles.
- FORMAT -> IDLE after one cycle.
REQ-015 On acceptance, a magnitude register SHALL be loaded with |value|; for SIGNED_MODE=1, -2^(DATA_WIDTH-1) SHALL yield magnitude 2^(DATA_WIDTH-1) without wrap. A sign flag SHALL be captured at the same time.
REQ-016 CONVERT SHALL perform one sequential double-dabble step per clock (add 3 to every BCD nibble >=5, then shift in one magnitude bit, MSB first), over BCD_DIGITS internal digits sufficient for 2^DATA_WIDTH-1.
REQ-017 In FORMAT, the block SHALL register the new values of segm_out and overflow and pulse done; ready SHALL be 1 in IDLE only.
REQ-018 Latency: if a value is accepted at edge k, then segm_out, overflow and done=1 SHALL take effect after edge k+DATA_WIDTH+1, and ready SHALL be 1 after edge k+DATA_WIDTH+2.
REQ-019 segm_out SHALL change atomically and only in FORMAT; it holds its value between updates.
REQ-020 Digit encodings (active-low, dp off) SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF, minus=BF (all hex).
REQ-021 Leading-zero blanking SHALL apply:
- Zeros left of the most significant non-zero digit are blank.
- Digit 0 is never blanked.
- If DP_POS>=0, no digit at index <=DP_POS is blanked.
REQ-022 If the value is negative, the minus sign SHALL occupy the digit immediately left of the leftmost shown digit.
REQ-023 Overflow SHALL be set when the number of digits required (plus 1 for a minus sign) exceeds NUM_DIGITS; in that case all digits SHALL show minus (BF) and the dp is not lit.
REQ-024 Unless in overflow, the dp bit (bit7) of digit DP_POS SHALL be driven 0 (lit); all other dp bits SHALL be 1.

Reset
REQ-025 While reset_reset_n=0, the block SHALL hold: state=IDLE, segm_out all 1 (blank), overflow=0, done=0, ready=1, and internal registers cleared.
REQ-026 Reset asserted mid-CONVERT SHALL abort the conversion; after release, no done is produced for the aborted value.

Structure
REQ-027 The package seg7_pkg SHALL hold:
- the state enum;
- the 16-entry segment encoding constants;
- the BLANK and MINUS constants;
- the function bcd_digits(width).
REQ-028 The digit encoder SHALL be the combinational sub-module seg7_encode (4-bit digit plus blank/minus controls -> 8-bit pattern), instantiated NUM_DIGITS times.

Verification
REQ-029 The bench SHALL use the default parameters and cover these scenarios:
- Send 1234 -> digits 5..0 = FF FF F9 A4 B0 99; overflow=0; done pulses 21 cycles after acceptance.
- Send -42 -> digit2=BF, digit1=99, digit0=A4; all others FF.
- Send 0 -> digit0=C0; others FF. Then send 524287 -> 92 A4 99 A4 80 F8.
- Send -524288 -> overflow=1; all digits BF.
- With DP_POS=2, send 5 -> digits 2..0 = 40 C0 92 (digit2 shows 0 with dp lit); others FF.
- Pulse value_valid with 7 while busy -> ignored (7 never displayed). Assert reset at cycle 10 of CONVERT -> segm_out all FF; ready=1 after release; no done pulse.
